// File: rtl/seq_stage_ctrl_pkg.sv
// Shared encodings for the Y86-64 SEQ stage sequencer: icodes, status codes,
// sequencer states and the icode classification helpers.
package seq_stage_ctrl_pkg;

    localparam logic [3:0] ICODE_HALT   = 4'h0;
    localparam logic [3:0] ICODE_RRMOVQ = 4'h2;
    localparam logic [3:0] ICODE_IRMOVQ = 4'h3;
    localparam logic [3:0] ICODE_RMMOVQ = 4'h4;
    localparam logic [3:0] ICODE_MRMOVQ = 4'h5;
    localparam logic [3:0] ICODE_OPQ    = 4'h6;
    localparam logic [3:0] ICODE_CALL   = 4'h8;
    localparam logic [3:0] ICODE_RET    = 4'h9;
    localparam logic [3:0] ICODE_PUSHQ  = 4'hA;
    localparam logic [3:0] ICODE_POPQ   = 4'hB;

    localparam int WAIT_W = 8;

    typedef enum logic [3:0] {
        STAT_AOK = 4'd1,
        STAT_HLT = 4'd2,
        STAT_ADR = 4'd3,
        STAT_INS = 4'd4
    } stat_e;

    typedef enum logic [2:0] {
        SEQ_ST_IDLE,
        SEQ_ST_FETCH,
        SEQ_ST_EXEC,
        SEQ_ST_MEM,
        SEQ_ST_WB,
        SEQ_ST_HALT,
        SEQ_ST_FAULT
    } seq_state_e;

    function automatic logic needs_mem(input logic [3:0] icode);
        logic r;
        r = 1'b0;
        case (icode)
            ICODE_RMMOVQ, ICODE_MRMOVQ, ICODE_CALL,
            ICODE_RET, ICODE_PUSHQ, ICODE_POPQ: r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic writes_rf(input logic [3:0] icode);
        logic r;
        r = 1'b0;
        case (icode)
            ICODE_RRMOVQ, ICODE_IRMOVQ, ICODE_MRMOVQ, ICODE_OPQ,
            ICODE_CALL, ICODE_RET, ICODE_PUSHQ, ICODE_POPQ: r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/seq_wait_timer.sv
// Memory-acknowledge wait counter shared by FETCH and MEM; flags the cycle
// whose increment would reach MEM_TIMEOUT.
module seq_wait_timer
    import seq_stage_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic expire
);

    localparam logic [WAIT_W-1:0] LAST = WAIT_W'(MEM_TIMEOUT - 1);

    logic [WAIT_W-1:0] count_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else if (inc) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    // Expiring on the edge that would make the count equal MEM_TIMEOUT keeps
    // the request high for exactly MEM_TIMEOUT cycles.
    assign expire = inc && (count_reg == LAST);

endmodule

// File: rtl/seq_stage_ctrl.sv
// Multi-cycle stage sequencer for the Y86-64 SEQ core.
// Optional performance counters are built when SEQ_CTRL_PERF_EN is defined.
module seq_stage_ctrl
    import seq_stage_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             run_i,
    input  logic [3:0]       icode_i,
    input  logic             instr_valid_i,
    input  logic             imem_error_i,
    input  logic             dmem_error_i,
    output logic             imem_req_o,
    input  logic             imem_ack_i,
    output logic             dmem_req_o,
    input  logic             dmem_ack_i,
    output logic             ir_we_o,
    output logic             cc_we_o,
    output logic             rf_we_o,
    output logic             pc_we_o,
    output logic [3:0]       stat_o,
    output logic             busy_o,
    output logic             retire_o
`ifdef SEQ_CTRL_PERF_EN
    ,
    output logic [CNT_W-1:0] instr_cnt_o,
    output logic [CNT_W-1:0] cycle_cnt_o
`endif
);

    seq_state_e state_reg;
    stat_e      stat_reg;
    logic [3:0] icode_reg;
    logic       wait_clr;
    logic       wait_inc;
    logic       wait_expire;

    // The counter idles at zero outside FETCH/MEM, so it is clear on entry.
    assign wait_clr = (state_reg != SEQ_ST_FETCH) && (state_reg != SEQ_ST_MEM);
    assign wait_inc = ((state_reg == SEQ_ST_FETCH) && !imem_ack_i) ||
                      ((state_reg == SEQ_ST_MEM)   && !dmem_ack_i);

    seq_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_wait_timer (
        .clk    (clk_i),
        .rst    (rst_i),
        .clr    (wait_clr),
        .inc    (wait_inc),
        .expire (wait_expire)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg <= SEQ_ST_IDLE;
            stat_reg  <= STAT_AOK;
            icode_reg <= 4'h0;
        end else begin
            case (state_reg)
                SEQ_ST_IDLE: begin
                    if (run_i) state_reg <= SEQ_ST_FETCH;
                end
                SEQ_ST_FETCH: begin
                    if (imem_ack_i) begin
                        if (imem_error_i) begin
                            state_reg <= SEQ_ST_FAULT;
                            stat_reg  <= STAT_ADR;
                        end else if (!instr_valid_i) begin
                            state_reg <= SEQ_ST_FAULT;
                            stat_reg  <= STAT_INS;
                        end else if (icode_i == ICODE_HALT) begin
                            state_reg <= SEQ_ST_HALT;
                            stat_reg  <= STAT_HLT;
                        end else begin
                            state_reg <= SEQ_ST_EXEC;
                            icode_reg <= icode_i;
                        end
                    end else if (wait_expire) begin
                        state_reg <= SEQ_ST_FAULT;
                        stat_reg  <= STAT_ADR;
                    end
                end
                SEQ_ST_EXEC: begin
                    state_reg <= needs_mem(icode_reg) ? SEQ_ST_MEM : SEQ_ST_WB;
                end
                SEQ_ST_MEM: begin
                    if (dmem_ack_i) begin
                        if (dmem_error_i) begin
                            state_reg <= SEQ_ST_FAULT;
                            stat_reg  <= STAT_ADR;
                        end else begin
                            state_reg <= SEQ_ST_WB;
                        end
                    end else if (wait_expire) begin
                        state_reg <= SEQ_ST_FAULT;
                        stat_reg  <= STAT_ADR;
                    end
                end
                SEQ_ST_WB: begin
                    state_reg <= run_i ? SEQ_ST_FETCH : SEQ_ST_IDLE;
                end
                SEQ_ST_HALT, SEQ_ST_FAULT: begin
                    state_reg <= state_reg;
                end
                default: begin
                    state_reg <= SEQ_ST_IDLE;
                end
            endcase
        end
    end

    // Moore decode: an async reset drops every enable in the same cycle.
    assign imem_req_o = (state_reg == SEQ_ST_FETCH);
    assign dmem_req_o = (state_reg == SEQ_ST_MEM);
    assign cc_we_o    = (state_reg == SEQ_ST_EXEC) && (icode_reg == ICODE_OPQ);
    assign rf_we_o    = (state_reg == SEQ_ST_WB) && writes_rf(icode_reg);
    assign pc_we_o    = (state_reg == SEQ_ST_WB);
    assign retire_o   = (state_reg == SEQ_ST_WB);
    assign busy_o     = (state_reg != SEQ_ST_IDLE) && (state_reg != SEQ_ST_HALT) &&
                        (state_reg != SEQ_ST_FAULT);
    assign stat_o     = stat_reg;
    assign ir_we_o    = (state_reg == SEQ_ST_FETCH) && imem_ack_i && !imem_error_i &&
                        instr_valid_i && (icode_i != ICODE_HALT);

`ifdef SEQ_CTRL_PERF_EN
    logic [CNT_W-1:0] instr_cnt_reg;
    logic [CNT_W-1:0] cycle_cnt_reg;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            instr_cnt_reg <= '0;
            cycle_cnt_reg <= '0;
        end else begin
            if (busy_o)   cycle_cnt_reg <= cycle_cnt_reg + 1'b1;
            if (retire_o) instr_cnt_reg <= instr_cnt_reg + 1'b1;
        end
    end

    assign instr_cnt_o = instr_cnt_reg;
    assign cycle_cnt_o = cycle_cnt_reg;
`else
    // Counter width only matters when the counters are built.
    if (CNT_W < 1) begin : g_no_counters
    end
`endif

endmodule

// File: tb/tb_seq_stage_ctrl.sv
// Self-checking bench for seq_stage_ctrl: table of instruction vectors with a
// scoreboard, plus hand-written reset, halt and run-drop sequences.
module tb_seq_stage_ctrl;

    localparam int TO = 4;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       run_i = 1'b0;
    logic [3:0] icode_i = 4'h1;
    logic       instr_valid_i = 1'b1;
    logic       imem_error_i = 1'b0;
    logic       dmem_error_i = 1'b0;
    logic       imem_ack_i = 1'b0;
    logic       dmem_ack_i = 1'b0;
    logic       imem_req_o, dmem_req_o, ir_we_o, cc_we_o, rf_we_o, pc_we_o;
    logic       busy_o, retire_o;
    logic [3:0] stat_o;
`ifdef SEQ_CTRL_PERF_EN
    logic [3:0] instr_cnt_o, cycle_cnt_o;
`endif

    always #5 clk_i = ~clk_i;

    seq_stage_ctrl #(
        .MEM_TIMEOUT (TO),
        .CNT_W       (4)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .run_i         (run_i),
        .icode_i       (icode_i),
        .instr_valid_i (instr_valid_i),
        .imem_error_i  (imem_error_i),
        .dmem_error_i  (dmem_error_i),
        .imem_req_o    (imem_req_o),
        .imem_ack_i    (imem_ack_i),
        .dmem_req_o    (dmem_req_o),
        .dmem_ack_i    (dmem_ack_i),
        .ir_we_o       (ir_we_o),
        .cc_we_o       (cc_we_o),
        .rf_we_o       (rf_we_o),
        .pc_we_o       (pc_we_o),
        .stat_o        (stat_o),
        .busy_o        (busy_o),
        .retire_o      (retire_o)
`ifdef SEQ_CTRL_PERF_EN
        ,
        .instr_cnt_o   (instr_cnt_o),
        .cycle_cnt_o   (cycle_cnt_o)
`endif
    );

    typedef struct {
        string      name;
        logic [3:0] icode;
        logic       valid;
        logic       ierr;
        int         iack_dly;
        int         dack_dly;
        logic       derr;
        logic       stray;
        int         cycles;
        logic [3:0] stat;
        int         n_ir;
        int         n_cc;
        int         n_rf;
        int         n_pc;
        int         n_dreq;
    } vec_t;

    int   n_cmp = 0;
    int   n_bad = 0;
    vec_t tab[17];
    vec_t exp_q[$];

    task automatic chk(input string name, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic do_reset(input logic run);
        @(posedge clk_i);
        #1;
        rst_i      = 1'b1;
        imem_ack_i = 1'b0;
        dmem_ack_i = 1'b0;
        run_i      = run;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
    endtask

    // Drives one instruction; memory acks follow the vector's delays.
    task automatic run_vec(input vec_t v);
        int   icnt = 0, dcnt = 0, cyc = 0;
        int   n_ir = 0, n_cc = 0, n_rf = 0, n_pc = 0, n_ret = 0, n_dreq = 0;
        bit   started = 0, done = 0;
        vec_t e;
        exp_q.push_back(v);
        for (int k = 0; k < 64 && !done; k++) begin
            @(posedge clk_i);
            #1;
            icode_i       = v.icode;
            instr_valid_i = v.valid;
            imem_error_i  = v.ierr;
            dmem_error_i  = v.derr;
            imem_ack_i    = imem_req_o && (icnt == v.iack_dly);
            if (imem_req_o) icnt++;
            dmem_ack_i    = dmem_req_o ? (dcnt == v.dack_dly) : v.stray;
            if (dmem_req_o) dcnt++;
            @(negedge clk_i);
            if (busy_o) begin
                started = 1;
                cyc++;
            end
            if (ir_we_o)    n_ir++;
            if (cc_we_o)    n_cc++;
            if (rf_we_o)    n_rf++;
            if (pc_we_o)    n_pc++;
            if (retire_o)   n_ret++;
            if (dmem_req_o) n_dreq++;
            if (retire_o || (started && !busy_o)) done = 1;
        end
        chk({v.name, " completed"}, int'(done), 1);
        e = exp_q.pop_front();
        chk({e.name, " cycles"}, cyc, e.cycles);
        chk({e.name, " stat"}, int'(stat_o), int'(e.stat));
        chk({e.name, " ir_we"}, n_ir, e.n_ir);
        chk({e.name, " cc_we"}, n_cc, e.n_cc);
        chk({e.name, " rf_we"}, n_rf, e.n_rf);
        chk({e.name, " pc_we"}, n_pc, e.n_pc);
        chk({e.name, " retire"}, n_ret, e.n_pc);
        chk({e.name, " dmem_req"}, n_dreq, e.n_dreq);
        $display("vec %s: cycles=%0d stat=%0d rf=%0d cc=%0d dreq=%0d",
                 e.name, cyc, stat_o, n_rf, n_cc, n_dreq);
    endtask

    task automatic chk_quiet(input string tag, input int want_stat);
        chk({tag, " imem_req"}, int'(imem_req_o), 0);
        chk({tag, " dmem_req"}, int'(dmem_req_o), 0);
        chk({tag, " ir_we"}, int'(ir_we_o), 0);
        chk({tag, " cc_we"}, int'(cc_we_o), 0);
        chk({tag, " rf_we"}, int'(rf_we_o), 0);
        chk({tag, " pc_we"}, int'(pc_we_o), 0);
        chk({tag, " retire"}, int'(retire_o), 0);
        chk({tag, " busy"}, int'(busy_o), 0);
        chk({tag, " stat"}, int'(stat_o), want_stat);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        //          name       icode valid ierr idly ddly derr stray cyc stat ir cc rf pc dreq
        tab[0]  = '{"nop",      4'h1, 1, 0,  0,  0, 0, 0, 3, 4'd1, 1, 0, 0, 1, 0};
        tab[1]  = '{"opq",      4'h6, 1, 0,  0,  0, 0, 0, 3, 4'd1, 1, 1, 1, 1, 0};
        tab[2]  = '{"mrmovq_d3",4'h5, 1, 0,  0,  3, 0, 0, 7, 4'd1, 1, 0, 1, 1, 4};
        tab[3]  = '{"rmmovq_i2",4'h4, 1, 0,  2,  0, 0, 0, 6, 4'd1, 1, 0, 0, 1, 1};
        tab[4]  = '{"irmovq_i1",4'h3, 1, 0,  1,  0, 0, 0, 4, 4'd1, 1, 0, 1, 1, 0};
        tab[5]  = '{"call_d1",  4'h8, 1, 0,  0,  1, 0, 0, 5, 4'd1, 1, 0, 1, 1, 2};
        tab[6]  = '{"jxx_stray",4'h7, 1, 0,  0,  0, 1, 1, 3, 4'd1, 1, 0, 0, 1, 0};
        tab[7]  = '{"icode_c",  4'hC, 1, 0,  0,  0, 0, 1, 3, 4'd1, 1, 0, 0, 1, 0};
        tab[8]  = '{"popq",     4'hB, 1, 0,  1,  2, 0, 0, 7, 4'd1, 1, 0, 1, 1, 3};
        tab[9]  = '{"ret_derr", 4'h9, 1, 0,  0,  0, 1, 0, 3, 4'd3, 1, 0, 0, 0, 1};
        tab[10] = '{"halt",     4'h0, 1, 0,  0,  0, 0, 0, 1, 4'd2, 0, 0, 0, 0, 0};
        tab[11] = '{"ierr_i1",  4'h0, 1, 1,  1,  0, 0, 0, 2, 4'd3, 0, 0, 0, 0, 0};
        tab[12] = '{"invalid",  4'h6, 0, 0,  0,  0, 0, 0, 1, 4'd4, 0, 0, 0, 0, 0};
        tab[13] = '{"inv_halt", 4'h0, 0, 0,  0,  0, 0, 0, 1, 4'd4, 0, 0, 0, 0, 0};
        tab[14] = '{"dmem_to",  4'h5, 1, 0,  0, 99, 0, 0, 6, 4'd3, 1, 0, 0, 0, 4};
        tab[15] = '{"imem_to",  4'h1, 1, 0, 99,  0, 0, 0, 4, 4'd3, 0, 0, 0, 0, 0};
        tab[16] = '{"ierr_inv", 4'h6, 0, 1,  0,  0, 0, 0, 1, 4'd3, 0, 0, 0, 0, 0};

        // Reset state.
        @(negedge clk_i);
        chk_quiet("reset", 1);
`ifdef SEQ_CTRL_PERF_EN
        chk("reset instr_cnt", int'(instr_cnt_o), 0);
        chk("reset cycle_cnt", int'(cycle_cnt_o), 0);
`endif

        do_reset(1'b1);
        for (int i = 0; i < 17; i++) begin
            run_vec(tab[i]);
            if (tab[i].stat != 4'd1) do_reset(1'b1);
        end

        // Halt is terminal: toggling run_i changes nothing.
        run_vec(tab[10]);
        for (int k = 0; k < 6; k++) begin
            @(posedge clk_i);
            #1;
            run_i = ~run_i;
            @(negedge clk_i);
            chk_quiet($sformatf("halt_hold%0d", k), 2);
        end

        // run_i dropped during EXEC: the instruction retires, then IDLE.
        do_reset(1'b1);
        icode_i = 4'h1; instr_valid_i = 1'b1; imem_error_i = 1'b0;
        dmem_error_i = 1'b0; dmem_ack_i = 1'b0;
        @(posedge clk_i); #1; imem_ack_i = 1'b1;
        @(posedge clk_i); #1; imem_ack_i = 1'b0; run_i = 1'b0;
        @(posedge clk_i); #1;
        @(negedge clk_i);
        chk("drop retire", int'(retire_o), 1);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk_i);
            chk_quiet($sformatf("drop_idle%0d", k), 1);
        end
        $display("seq run_drop: retired then parked");

        // Asynchronous reset in the middle of a memory wait.
        do_reset(1'b1);
        icode_i = 4'h5;
        @(posedge clk_i); #1; imem_ack_i = 1'b1;
        @(posedge clk_i); #1; imem_ack_i = 1'b0;
        @(posedge clk_i); #1;
        @(posedge clk_i); #2;
        chk("midmem dmem_req", int'(dmem_req_o), 1);
        chk("midmem busy", int'(busy_o), 1);
        rst_i = 1'b1;
        #1;
        chk_quiet("midmem_rst", 1);
        run_i = 1'b0;
        @(posedge clk_i); #1; rst_i = 1'b0;
        repeat (2) begin
            @(negedge clk_i);
            chk_quiet("after_rst", 1);
        end
        $display("seq reset_mid_mem: outputs dropped");

`ifdef SEQ_CTRL_PERF_EN
        // 17 nops with 4-bit counters: 17 retires and 51 busy cycles wrap.
        do_reset(1'b1);
        for (int i = 0; i < 17; i++) run_vec(tab[0]);
        run_i = 1'b0;
        @(posedge clk_i); #1;
        @(negedge clk_i);
        chk("perf busy", int'(busy_o), 0);
        chk("perf instr_cnt", int'(instr_cnt_o), 1);
        chk("perf cycle_cnt", int'(cycle_cnt_o), 3);
        $display("seq perf: instr_cnt=%0d cycle_cnt=%0d", instr_cnt_o, cycle_cnt_o);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/seq_stage_ctrl.md
# seq_stage_ctrl

Multi-cycle stage sequencer for the Y86-64 SEQ core. It steps each instruction through the fetch, execute, memory and write-back/PC-update phases. It drives the request/acknowledge handshakes to instruction and data memory, and issues the single-cycle write enables for the condition codes, register file and PC. It owns the architectural status code (AOK/HLT/ADR/INS) and stops the core on halt or fault. It sits in `cpu_top` beside the fetch, decode/write-back, execute, memory and new-PC units; those units stay combinational or register only under its enables.

## Interface
Parameters:
- `MEM_TIMEOUT`, default 15: maximum wait cycles for a memory acknowledge before an ADR fault is declared; range 1–255.
- `CNT_W`, default 32: width of the performance counters; used only with `SEQ_CTRL_PERF_EN`.

Ports:
- `clk_i` input 1: single clock; all state is updated on the rising edge.
- `rst_i` input 1: reset, asynchronous and active-high.
- `run_i` input 1: level; allows a new instruction to start.
- `icode_i` input 4: instruction code from the fetch unit.
- `instr_valid_i` input 1: fetch decoded a legal instruction.
- `imem_error_i` input 1: instruction address error; qualified by `imem_ack_i`.
- `dmem_error_i` input 1: data address error; qualified by `dmem_ack_i`.
- `imem_req_o` output 1, `imem_ack_i` input 1: instruction memory handshake.
- `dmem_req_o` output 1, `dmem_ack_i` input 1: data memory handshake.
- `ir_we_o` output 1: latch the fetched instruction bytes.
- `cc_we_o` output 1: update the condition codes.
- `rf_we_o` output 1: register-file write (the datapath gates cmov with Cnd).
- `pc_we_o` output 1: load the new PC.
- `stat_o` output 4: status code; AOK=1, HLT=2, ADR=3, INS=4.
- `busy_o` output 1: high in any state other than IDLE, HALT or FAULT.
- `retire_o` output 1: one-cycle pulse per completed instruction.
- `instr_cnt_o` output `CNT_W`, `cycle_cnt_o` output `CNT_W`: performance counters; present only with the macro.

## Operation
States are IDLE, FETCH, EXEC, MEM, WB, HALT and FAULT.
- **IDLE:** if `run_i` is high, go to FETCH; otherwise hold.
- **FETCH:** `imem_req_o` is held high until `imem_ack_i`. On the ack cycle, checks apply in this priority:
  - `imem_error_i` high: go to FAULT, stat=ADR.
  - `instr_valid_i` low: go to FAULT, stat=INS.
  - `icode_i` = 0 (halt): go to HALT, stat=HLT.
  - Otherwise pulse `ir_we_o` and go to EXEC.
- **EXEC:** one cycle. `cc_we_o` is high only when icode = 6 (OPq). Next state is MEM for icode 4, 5, 8, 9, A or B; otherwise WB.
- **MEM:** `dmem_req_o` is held high until `dmem_ack_i`.
  - Ack with `dmem_error_i` high: go to FAULT, stat=ADR.
  - Ack with no error: go to WB.
- **WB:** one cycle.
  - `pc_we_o` and `retire_o` are high.
  - `rf_we_o` is high for icode 2, 3, 5, 6, 8, 9, A and B.
  - Next state is FETCH if `run_i` is high, otherwise IDLE.
- **HALT and FAULT:** terminal. All enables and requests are low and `stat_o` is held. Only `rst_i` leaves these states. The PC is not written, so it still points at the faulting or halt instruction.
- **Timeout:** a wait counter clears on entry to FETCH and to MEM, and increments each cycle the request is high without an ack. If it reaches `MEM_TIMEOUT` without an ack, go to FAULT with stat=ADR and drop the request.
- **Ack qualification:** an ack while the matching request is low is ignored. An error input without its ack is ignored.
- **Unused icodes:** illegal icodes are flagged by fetch through `instr_valid_i`. Any other icode not listed above takes the non-memory, no-writeback path.
- **run_i deasserted mid-instruction:** the current instruction completes through WB, then the block parks in IDLE.

## Timing
- Reset state: IDLE, `stat_o`=1 (AOK). All other outputs are 0, including the counters.
- Requests, write enables and `retire_o` are Moore outputs decoded from the state register. The exception is `ir_we_o`, which is combinational on `imem_ack_i` in FETCH.
- With the ack in the same cycle as the request, latency is 3 cycles for non-memory instructions (FETCH, EXEC, WB) and 4 cycles for memory instructions.
- Each cycle of ack delay adds one cycle.
- Back-to-back instructions: FETCH follows WB immediately, with no bubble.
- The transition to FAULT on timeout happens on the edge at which the counter equals `MEM_TIMEOUT`. The request is therefore high for exactly `MEM_TIMEOUT` cycles.
- Asynchronous reset mid-instruction: all outputs drop immediately, with no partial write enables. A memory handshake in progress is abandoned, and memory must tolerate that.

## Configuration
- `SEQ_CTRL_PERF_EN` defined:
  - `cycle_cnt_o` increments each cycle `busy_o` is high.
  - `instr_cnt_o` increments on each `retire_o`.
  - Both wrap modulo 2^`CNT_W` and clear on reset.
- Not defined: both counter ports and their logic are absent.

## Structure
- The icode values, status codes and state encodings belong in the shared `define.v` header, named `` `ICODE_* ``, `` `STAT_* `` and `` `SEQ_ST_* ``.
- One sub-module is natural: `seq_wait_timer`. It is an 8-bit clear/increment counter with a compare against `MEM_TIMEOUT`, and is instanced once because FETCH and MEM are exclusive.

## Test plan
- **Reset:** assert `rst_i` mid-MEM → all outputs 0 in the same cycle, stat=1, state IDLE after release.
- **Nop and OPq, zero-delay acks:** nop then OPq → 3 cycles each and two `retire_o` pulses. `cc_we_o` is high only during the OPq EXEC cycle, and `rf_we_o` only in the OPq WB cycle.
- **mrmovq with delayed data ack:** `dmem_ack_i` after 3 cycles → 7 cycles total, with `rf_we_o` and `pc_we_o` high in the final cycle.
- **Halt:** icode 0 → stat=2, `busy_o`=0, no `pc_we_o`; `run_i` toggling afterwards has no effect.
- **Fetch errors:** `imem_error_i` on the ack → stat=3. `instr_valid_i`=0 → stat=4.
- **Timeout:** `MEM_TIMEOUT`=4 with no `dmem_ack_i` → `dmem_req_o` high for 4 cycles, then FAULT with stat=3.
- **Performance counters:** with `SEQ_CTRL_PERF_EN` and `CNT_W`=4, retire 17 nops → `instr_cnt_o`=1 (wrap).
